// File: rtl/clock_text_renderer_pkg.sv
// Glyph codes and ROM bank mapping shared by the clock text renderer.
package clock_text_renderer_pkg;

    localparam logic [3:0] GLYPH_COLON = 4'd10;
    localparam logic [3:0] GLYPH_RING  = 4'd11;
    localparam logic [3:0] BANK_BASE   = 4'd4;
    localparam logic [3:0] BLANK_SEL   = 4'd0;

    // Each ROM bank holds four glyphs, so the upper two code bits pick the bank.
    function automatic logic [3:0] glyph_bank(input logic [3:0] glyph);
        return BANK_BASE + {2'b00, glyph[3:2]};
    endfunction

endpackage

// File: rtl/clock_text_renderer_if.sv
// Video, time and glyph ROM signals between the raster environment and the renderer.
interface clock_text_renderer_if;

    logic        pixel_tick;
    logic        video_on;
    logic [9:0]  pixel_x;
    logic [9:0]  pixel_y;
    logic [23:0] bcd_time;
    logic        ring;
    logic [3:0]  rom_sel;
    logic [1:0]  rom_AD;
    logic [3:0]  rom_lsby;
    logic [7:0]  rom_data;
    logic        text_on;
    logic [11:0] text_rgb;

    modport master (
        output pixel_tick, video_on, pixel_x, pixel_y, bcd_time, ring, rom_data,
        input  rom_sel, rom_AD, rom_lsby, text_on, text_rgb
    );

    modport slave (
        input  pixel_tick, video_on, pixel_x, pixel_y, bcd_time, ring, rom_data,
        output rom_sel, rom_AD, rom_lsby, text_on, text_rgb
    );

endinterface

// File: rtl/text_blink_ctrl.sv
// Frame-start detection, frame-synchronous time shadow and ring-glyph blink timing.
module text_blink_ctrl #(
    parameter int unsigned BLINK_FRAMES = 30
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pixel_tick,
    input  logic [9:0]  pixel_x,
    input  logic [9:0]  pixel_y,
    input  logic [23:0] bcd_time,
    input  logic        ring,
    output logic [23:0] shadow_time,
    output logic        blink_phase
);

    localparam int unsigned CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

    logic             frame_start;
    logic [23:0]      shadow_q, shadow_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             phase_q, phase_d;

    assign frame_start = pixel_tick && (pixel_x == 10'd0) && (pixel_y == 10'd0);

    always_comb begin
        shadow_d = frame_start ? bcd_time : shadow_q;
        cnt_d    = cnt_q;
        phase_d  = phase_q;
        // Holding phase high while idle makes the glyph visible as soon as ring asserts.
        if (!ring) begin
            cnt_d   = '0;
            phase_d = 1'b1;
        end else if (frame_start) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d   = '0;
                phase_d = ~phase_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow_q <= '0;
            cnt_q    <= '0;
            phase_q  <= 1'b1;
        end else begin
            shadow_q <= shadow_d;
            cnt_q    <= cnt_d;
            phase_q  <= phase_d;
        end
    end

    assign shadow_time = shadow_q;
    assign blink_phase = phase_q;

endmodule

// File: rtl/clock_text_renderer.sv
// Renders "HH:MM:SS" plus a blinking ring glyph from a combinational glyph ROM, 2-tick latency.
module clock_text_renderer
    import clock_text_renderer_pkg::*;
#(
    parameter int unsigned X0           = 256,
    parameter int unsigned Y0           = 224,
    parameter int unsigned SCALE_LOG2   = 1,
    parameter int unsigned BLINK_FRAMES = 30,
    parameter logic [11:0] FG_COLOR     = 12'hFFF
) (
    input logic                  clk,
    input logic                  reset,
    clock_text_renderer_if.slave bus
);

    localparam int unsigned CELL_W  = 8 << SCALE_LOG2;
    localparam int unsigned CELL_H  = 16 << SCALE_LOG2;
    localparam logic [10:0] X_BEGIN = 11'(X0);
    localparam logic [10:0] X_END   = 11'(X0 + 9 * CELL_W);
    localparam logic [10:0] Y_BEGIN = 11'(Y0);
    localparam logic [10:0] Y_END   = 11'(Y0 + CELL_H);

    logic [23:0] shadow_time;
    logic        blink_phase;

    text_blink_ctrl #(
        .BLINK_FRAMES(BLINK_FRAMES)
    ) u_blink (
        .clk        (clk),
        .reset      (reset),
        .pixel_tick (bus.pixel_tick),
        .pixel_x    (bus.pixel_x),
        .pixel_y    (bus.pixel_y),
        .bcd_time   (bus.bcd_time),
        .ring       (bus.ring),
        .shadow_time(shadow_time),
        .blink_phase(blink_phase)
    );

    logic       in_field;
    logic [9:0] dx, dy;
    logic [3:0] slot, row;
    logic [2:0] col;

    assign in_field = ({1'b0, bus.pixel_x} >= X_BEGIN) && ({1'b0, bus.pixel_x} < X_END) &&
                      ({1'b0, bus.pixel_y} >= Y_BEGIN) && ({1'b0, bus.pixel_y} < Y_END);
    assign dx   = bus.pixel_x - 10'(X0);
    assign dy   = bus.pixel_y - 10'(Y0);
    assign slot = 4'((dx >> SCALE_LOG2) >> 3);
    assign col  = 3'(dx >> SCALE_LOG2);
    assign row  = 4'(dy >> SCALE_LOG2);

    logic [3:0] glyph, sel_d, lsby_d;
    logic [1:0] ad_d;
    logic       shown, is_digit;

    always_comb begin
        glyph    = GLYPH_COLON;
        shown    = 1'b1;
        is_digit = 1'b1;
        case (slot)
            4'd0:       glyph = shadow_time[23:20];
            4'd1:       glyph = shadow_time[19:16];
            4'd3:       glyph = shadow_time[15:12];
            4'd4:       glyph = shadow_time[11:8];
            4'd6:       glyph = shadow_time[7:4];
            4'd7:       glyph = shadow_time[3:0];
            4'd2, 4'd5: is_digit = 1'b0;
            4'd8: begin
                glyph    = GLYPH_RING;
                is_digit = 1'b0;
                shown    = bus.ring & blink_phase;
            end
            default: begin
                is_digit = 1'b0;
                shown    = 1'b0;
            end
        endcase
        if (is_digit && (glyph > 4'd9)) shown = 1'b0;
        if (!in_field) shown = 1'b0;
        sel_d  = shown ? glyph_bank(glyph) : BLANK_SEL;
        ad_d   = shown ? glyph[1:0] : 2'd0;
        lsby_d = in_field ? row : 4'd0;
    end

    logic [3:0] rom_sel_q, rom_lsby_q;
    logic [1:0] rom_ad_q;
    logic [2:0] col_q;
    logic       in_field_q, video_on_q, text_on_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rom_sel_q  <= '0;
            rom_ad_q   <= '0;
            rom_lsby_q <= '0;
            col_q      <= '0;
            in_field_q <= 1'b0;
            video_on_q <= 1'b0;
            text_on_q  <= 1'b0;
        end else if (bus.pixel_tick) begin
            rom_sel_q  <= sel_d;
            rom_ad_q   <= ad_d;
            rom_lsby_q <= lsby_d;
            col_q      <= col;
            in_field_q <= in_field;
            video_on_q <= bus.video_on;
            // Bit 7 is the leftmost pixel, so ~col selects bit 7-col.
            text_on_q  <= bus.rom_data[~col_q] & in_field_q & video_on_q;
        end
    end

    assign bus.rom_sel  = rom_sel_q;
    assign bus.rom_AD   = rom_ad_q;
    assign bus.rom_lsby = rom_lsby_q;
    assign bus.text_on  = text_on_q;
    assign bus.text_rgb = text_on_q ? FG_COLOR : 12'h000;

endmodule

// File: tb/tb_clock_text_renderer.sv
// Scoreboard bench for clock_text_renderer with a behavioural glyph ROM and raster model.
module tb_clock_text_renderer;

    localparam int          X0           = 256;
    localparam int          Y0           = 224;
    localparam int          SCALE_LOG2   = 1;
    localparam int          BLINK_FRAMES = 30;
    localparam logic [11:0] FG_COLOR     = 12'hFFF;
    localparam int          CELL_W       = 8 << SCALE_LOG2;
    localparam int          CELL_H       = 16 << SCALE_LOG2;

    typedef struct packed {
        logic [3:0] sel;
        logic [1:0] ad;
        logic [3:0] lsby;
        logic       txt;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    int          checks = 0;
    int          failures = 0;
    exp_t        rom_q[$];
    exp_t        txt_q[$];
    exp_t        last_rom, last_txt;
    logic [23:0] m_time, m_shadow;
    logic        m_ring;
    int          m_starts;

    clock_text_renderer_if bus ();

    clock_text_renderer #(
        .X0          (X0),
        .Y0          (Y0),
        .SCALE_LOG2  (SCALE_LOG2),
        .BLINK_FRAMES(BLINK_FRAMES),
        .FG_COLOR    (FG_COLOR)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] rom_model(input logic [3:0] sel, input logic [1:0] ad,
                                             input logic [3:0] row);
        if (sel == 4'd0) return 8'h00;
        if (sel == 4'd4 && ad == 2'd1 && row == 4'd1) return 8'b0001_0000;
        if (sel == 4'd6 && ad == 2'd2 && row == 4'd5) return 8'b0011_0000;
        return 8'((int'(sel) * 29) ^ (int'(ad) * 77) ^ (int'(row) * 19) ^ 165);
    endfunction

    assign bus.rom_data = rom_model(bus.rom_sel, bus.rom_AD, bus.rom_lsby);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input int x, input int y, input logic vid);
        exp_t       e;
        int         dx, dy, slot, col, g;
        logic       show, is_digit;
        logic [7:0] pat;
        e = '0;
        if (x < X0 || x >= X0 + 9 * CELL_W || y < Y0 || y >= Y0 + CELL_H) return e;
        dx     = x - X0;
        dy     = y - Y0;
        slot   = dx / CELL_W;
        col    = (dx % CELL_W) / (CELL_W / 8);
        e.lsby = 4'(dy / (CELL_H / 16));
        is_digit = !(slot == 2 || slot == 5 || slot == 8);
        show     = 1'b1;
        if (slot == 2 || slot == 5) begin
            g = 10;
        end else if (slot == 8) begin
            g    = 11;
            show = m_ring && ((m_starts / BLINK_FRAMES) % 2 == 0);
        end else begin
            g = int'((m_shadow >> (4 * (5 - (slot - slot / 3)))) & 24'hF);
        end
        if (is_digit && g > 9) show = 1'b0;
        if (show) begin
            e.sel = 4'(4 + g / 4);
            e.ad  = 2'(g % 4);
        end
        pat   = rom_model(e.sel, e.ad, e.lsby);
        e.txt = vid && pat[7 - col];
        return e;
    endfunction

    task automatic set_time(input logic [23:0] t);
        m_time       = t;
        bus.bcd_time = t;
    endtask

    task automatic set_ring(input logic v);
        m_ring   = v;
        bus.ring = v;
        if (!v) m_starts = 0;
    endtask

    task automatic pix(input int x, input int y, input logic vid);
        exp_t e, r;
        e = model(x, y, vid);
        bus.pixel_x    = 10'(x);
        bus.pixel_y    = 10'(y);
        bus.video_on   = vid;
        bus.pixel_tick = 1'b1;
        @(posedge clk);
        if (x == 0 && y == 0) begin
            m_shadow = m_time;
            if (m_ring) m_starts++;
        end
        rom_q.push_back(e);
        txt_q.push_back(e);
        #1;
        bus.pixel_tick = 1'b0;
        r        = rom_q.pop_front();
        last_rom = r;
        check("rom_sel", 32'(bus.rom_sel), 32'(r.sel));
        if (r.sel != 4'd0) begin
            check("rom_AD", 32'(bus.rom_AD), 32'(r.ad));
            check("rom_lsby", 32'(bus.rom_lsby), 32'(r.lsby));
        end
        if (txt_q.size() > 1) begin
            r        = txt_q.pop_front();
            last_txt = r;
            check("text_on", 32'(bus.text_on), 32'(r.txt));
            check("text_rgb", 32'(bus.text_rgb), 32'(r.txt ? FG_COLOR : 12'h000));
        end
    endtask

    task automatic clear_model();
        rom_q.delete();
        txt_q.delete();
        m_shadow = '0;
        m_starts = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset          = 1'b1;
        bus.pixel_tick = 1'b0;
        bus.video_on   = 1'b0;
        bus.pixel_x    = '0;
        bus.pixel_y    = '0;
        set_time(24'h000000);
        set_ring(1'b0);
        clear_model();
        #12;
        check("rst_sel", 32'(bus.rom_sel), 32'd0);
        check("rst_AD", 32'(bus.rom_AD), 32'd0);
        check("rst_lsby", 32'(bus.rom_lsby), 32'd0);
        check("rst_text", 32'(bus.text_on), 32'd0);
        check("rst_rgb", 32'(bus.text_rgb), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Digit at slot 0 and the first colon
        set_time(24'h123456);
        pix(0, 0, 1'b0);
        pix(262, 226, 1'b1);
        pix(262, 226, 1'b1);
        pix(X0 + 36, Y0 + 10, 1'b1);
        pix(X0 + 36, Y0 + 10, 1'b1);

        // Stalled pixel_tick must freeze every output
        for (int i = 0; i < 5; i++) begin
            bus.pixel_x  = 10'($urandom_range(1, 1023));
            bus.pixel_y  = 10'($urandom_range(1, 1023));
            bus.video_on = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            check("frz_sel", 32'(bus.rom_sel), 32'(last_rom.sel));
            check("frz_text", 32'(bus.text_on), 32'(last_txt.txt));
        end

        // New time mid-frame stays hidden until the next frame start
        pix(X0 + 2, Y0 + 2, 1'b1);
        set_time(24'h975800);
        pix(X0 + 2, Y0 + 2, 1'b1);
        pix(0, 0, 1'b0);
        for (int s = 0; s < 8; s++) pix(X0 + 2 + s * CELL_W, Y0 + 2, 1'b1);
        set_time(24'hA75800);
        pix(0, 0, 1'b0);
        pix(X0 + 2, Y0 + 2, 1'b1);
        pix(X0 + 4, Y0 + 8, 1'b1);

        // Random sweep around the field
        set_time(24'h235947);
        pix(0, 0, 1'b0);
        for (int i = 0; i < 200; i++) begin
            pix(X0 - 8 + int'($urandom_range(0, 9 * CELL_W + 15)),
                Y0 - 4 + int'($urandom_range(0, CELL_H + 7)), 1'($urandom_range(0, 3) != 0));
        end

        // Ring glyph blink over 61 frames, ring raised just after a frame start
        set_time(24'h123456);
        pix(0, 0, 1'b0);
        set_ring(1'b1);
        for (int f = 0; f <= 60; f++) begin
            if (f > 0) pix(0, 0, 1'b0);
            pix(X0 + 132, Y0 + 6, 1'b1);
            pix(X0 + 132, Y0 + 6, 1'b1);
        end
        set_ring(1'b0);
        pix(X0 + 132, Y0 + 6, 1'b1);
        pix(X0 + 132, Y0 + 6, 1'b1);

        // Asynchronous reset while text is lit
        pix(0, 0, 1'b0);
        pix(262, 226, 1'b1);
        pix(262, 226, 1'b1);
        reset = 1'b1;
        #1;
        check("async_text", 32'(bus.text_on), 32'd0);
        check("async_rgb", 32'(bus.text_rgb), 32'd0);
        check("async_sel", 32'(bus.rom_sel), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        clear_model();

        // video_on low inside the field blanks the text
        pix(0, 0, 1'b0);
        pix(262, 226, 1'b0);
        pix(262, 226, 1'b0);
        pix(262, 226, 1'b1);
        pix(262, 226, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
